// File: rtl/seq_rca_if.sv
// ---------------------------------------------------------------------------
// seq_rca_if
// Groups the start/done handshake, operands and result of seq_rca.
//
//   start  requester -> adder   start request (only sampled while idle)
//   a, b   requester -> adder   WIDTH-bit operands
//   ci     requester -> adder   carry-in
//   busy   adder -> requester   high while an add is in flight or completing
//   done   adder -> requester   one-cycle pulse, result valid
//   s      adder -> requester   WIDTH-bit sum register
//   co     adder -> requester   final carry-out
//   ovf    adder -> requester   two's-complement overflow
//
// master: the block issuing adds. slave: the adder itself.
// ---------------------------------------------------------------------------
interface seq_rca_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, s, co, ovf
    );
endinterface

// File: rtl/seq_rca.sv
// ---------------------------------------------------------------------------
// seq_rca
// Multi-cycle ripple-carry adder. Adds two WIDTH-bit operands plus carry-in,
// CHUNK bits per clock, with the inter-chunk carry held in a register, so the
// combinational carry chain is only CHUNK full adders long.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset, clears every register
//   bus      seq_rca_if slave modport (start/a/b/ci in, busy/done/s/co/ovf out)
//
// Timing: start accepted in IDLE at edge E0; N = WIDTH/CHUNK RUN cycles follow;
// the result is published at the last RUN edge and done pulses for one cycle.
// s/co/ovf only ever change at that edge, so they hold the previous result
// for the whole of the next operation.
// ---------------------------------------------------------------------------
module seq_rca #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    seq_rca_if.slave bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               busy_c;
    logic               done_c;

    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   psum;
    logic [WIDTH-1:0]   psum_nxt;
    logic [WIDTH-1:0]   s_reg;
    logic               co_reg;
    logic               ovf_reg;

    logic [CHUNK-1:0]   slice_sum;
    logic               slice_co;
    logic               slice_cm;
    logic               last;
    int                 lo;

    // CHUNK chained full adders. Returns {carry into slice MSB, carry out, sum}.
    // The carry into the MSB is only meaningful on the top slice, where it
    // feeds the overflow flag.
    function automatic logic [CHUNK+1:0] fa_slice(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             cin
    );
        logic [CHUNK-1:0] sum;
        logic             c;
        logic             cm;
        c  = cin;
        cm = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            cm     = c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {cm, c, sum};
    endfunction

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM next state and handshake outputs ----
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- Slice adder: current chunk of the latched operands ----
    always_comb begin
        lo       = int'(cnt) * CHUNK;
        last     = (cnt == CNT_W'(N - 1));
        {slice_cm, slice_co, slice_sum} = fa_slice(a_reg[lo +: CHUNK], b_reg[lo +: CHUNK], carry);
        // Full partial sum including this cycle's slice, so the last RUN edge
        // can publish the complete word in one step.
        psum_nxt = psum;
        psum_nxt[lo +: CHUNK] = slice_sum;
    end

    // ---- Datapath registers ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            psum    <= '0;
            s_reg   <= '0;
            co_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.a;
                        b_reg <= bus.b;
                        carry <= bus.ci;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    psum  <= psum_nxt;
                    carry <= slice_co;
                    // Counter wraps back to 0 on the last slice so the slice
                    // index never points past the operand.
                    cnt   <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        s_reg   <= psum_nxt;
                        co_reg  <= slice_co;
                        ovf_reg <= slice_cm ^ slice_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.s    = s_reg;
    assign bus.co   = co_reg;
    assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_rca.sv
// ---------------------------------------------------------------------------
// tb_seq_rca
// Three adders side by side: WIDTH=8/CHUNK=2, WIDTH=4/CHUNK=1, WIDTH=8/CHUNK=8.
// An arithmetic model (whole-word add, signed-overflow rule, cycle countdown
// from acceptance) is compared against every adder on every falling edge;
// directed tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_seq_rca;

    localparam int WW [3] = '{8, 4, 8};
    localparam int NN [3] = '{4, 4, 1};

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic chk_en  = 1'b0;

    logic       istart [3];
    logic [7:0] ia     [3];
    logic [7:0] ib     [3];
    logic       ici    [3];

    logic [7:0] os    [3];
    logic       obusy [3];
    logic       odone [3];
    logic       oco   [3];
    logic       oovf  [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_rca_if #(.WIDTH(8)) bus0 ();
    seq_rca_if #(.WIDTH(4)) bus1 ();
    seq_rca_if #(.WIDTH(8)) bus2 ();

    seq_rca #(.WIDTH(8), .CHUNK(2)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    seq_rca #(.WIDTH(4), .CHUNK(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    seq_rca #(.WIDTH(8), .CHUNK(8)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    assign bus0.start = istart[0];
    assign bus0.a     = ia[0];
    assign bus0.b     = ib[0];
    assign bus0.ci    = ici[0];
    assign bus1.start = istart[1];
    assign bus1.a     = ia[1][3:0];
    assign bus1.b     = ib[1][3:0];
    assign bus1.ci    = ici[1];
    assign bus2.start = istart[2];
    assign bus2.a     = ia[2];
    assign bus2.b     = ib[2];
    assign bus2.ci    = ici[2];

    assign os[0] = bus0.s;
    assign os[1] = {4'b0000, bus1.s};
    assign os[2] = bus2.s;
    assign obusy[0] = bus0.busy;
    assign obusy[1] = bus1.busy;
    assign obusy[2] = bus2.busy;
    assign odone[0] = bus0.done;
    assign odone[1] = bus1.done;
    assign odone[2] = bus2.done;
    assign oco[0] = bus0.co;
    assign oco[1] = bus1.co;
    assign oco[2] = bus2.co;
    assign oovf[0] = bus0.ovf;
    assign oovf[1] = bus1.ovf;
    assign oovf[2] = bus2.ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // ---- Model: whole-word sum computed at acceptance, released after N edges ----
    int   m_left [3];
    int   m_s    [3];
    logic m_co   [3];
    logic m_ovf  [3];
    int   p_s    [3];
    logic p_co   [3];
    logic p_ovf  [3];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                m_left[i] = 0;
                m_s[i]    = 0;
                m_co[i]   = 1'b0;
                m_ovf[i]  = 1'b0;
            end else if (m_left[i] == 0) begin
                if (istart[i]) begin
                    int w, mask, av, bv, tot, sa, sb, ss;
                    w    = WW[i];
                    mask = (1 << w) - 1;
                    av   = int'(ia[i]) & mask;
                    bv   = int'(ib[i]) & mask;
                    tot  = av + bv + int'(ici[i]);
                    p_s[i]  = tot & mask;
                    p_co[i] = ((tot >> w) & 1) != 0;
                    sa = (av >> (w - 1)) & 1;
                    sb = (bv >> (w - 1)) & 1;
                    ss = (p_s[i] >> (w - 1)) & 1;
                    p_ovf[i]  = (sa == sb) && (ss != sa);
                    m_left[i] = NN[i] + 1;
                end
            end else begin
                m_left[i]--;
                if (m_left[i] == 1) begin
                    m_s[i]   = p_s[i];
                    m_co[i]  = p_co[i];
                    m_ovf[i] = p_ovf[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("dut%0d.busy", i), 32'(obusy[i]), 32'(m_left[i] != 0));
                chk($sformatf("dut%0d.done", i), 32'(odone[i]), 32'(m_left[i] == 1));
                chk($sformatf("dut%0d.s", i),    32'(os[i]),    32'(m_s[i]));
                chk($sformatf("dut%0d.co", i),   32'(oco[i]),   32'(m_co[i]));
                chk($sformatf("dut%0d.ovf", i),  32'(oovf[i]),  32'(m_ovf[i]));
            end
        end
    end

    // Issue one add on adder i (idle assumed); scramble operands right after E0.
    // edges: edges after E0 until done observed; bcnt: busy cycles; held: s after E0.
    task automatic run_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, output int edges, output int bcnt,
                          output logic [7:0] held);
        @(posedge clk);
        #2;
        istart[i] = 1'b1;
        ia[i] = av;
        ib[i] = bv;
        ici[i] = cv;
        @(posedge clk);
        #2;
        istart[i] = 1'b0;
        ia[i]  = ~av;
        ib[i]  = bv ^ 8'h5A;
        ici[i] = ~cv;
        @(negedge clk);
        held  = os[i];
        bcnt  = obusy[i] ? 1 : 0;
        edges = 0;
        while (!odone[i] && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (obusy[i]) bcnt++;
        end
        chk($sformatf("dut%0d.done_seen", i), 32'(odone[i]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, bc, nd;
        logic [7:0] hd;
        logic prev;
        for (int i = 0; i < 3; i++) begin
            istart[i] = 1'b0;
            ia[i] = 8'h00;
            ib[i] = 8'h00;
            ici[i] = 1'b0;
        end
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset.busy", 32'(obusy[0]), 32'd0);
        chk("reset.done", 32'(odone[0]), 32'd0);
        chk("reset.s",    32'(os[0]),    32'd0);
        chk("reset.co",   32'(oco[0]),   32'd0);

        // 0x5A + 0x3C = 0x96: two positives giving a negative
        run_op(0, 8'h5A, 8'h3C, 1'b0, e, bc, hd);
        chk("t1.latency", 32'(e),  32'd4);
        chk("t1.busy_cycles", 32'(bc), 32'd5);
        chk("t1.s",   32'(os[0]),   32'h96);
        chk("t1.co",  32'(oco[0]),  32'd0);
        chk("t1.ovf", 32'(oovf[0]), 32'd1);

        run_op(0, 8'hFF, 8'h01, 1'b0, e, bc, hd);
        chk("t2a.s",   32'(os[0]),   32'h00);
        chk("t2a.co",  32'(oco[0]),  32'd1);
        chk("t2a.ovf", 32'(oovf[0]), 32'd0);
        run_op(0, 8'h80, 8'h80, 1'b1, e, bc, hd);
        chk("t2b.held_s", 32'(hd),    32'h00);
        chk("t2b.s",   32'(os[0]),   32'h01);
        chk("t2b.co",  32'(oco[0]),  32'd1);
        chk("t2b.ovf", 32'(oovf[0]), 32'd1);

        // start held high: accepted every N+2 cycles, never back-to-back done
        @(posedge clk);
        #2;
        istart[0] = 1'b1;
        ia[0] = 8'h11;
        ib[0] = 8'h22;
        ici[0] = 1'b0;
        nd = 0;
        prev = 1'b0;
        repeat (18) begin
            @(negedge clk);
            if (odone[0]) begin
                nd++;
                chk("t3.s", 32'(os[0]), 32'h33);
                chk("t3.no_consecutive_done", 32'(prev), 32'd0);
            end
            prev = odone[0];
        end
        istart[0] = 1'b0;
        chk("t3.done_count", 32'(nd), 32'd3);

        // reset at E2 of a run
        @(posedge clk);
        @(posedge clk);
        #2;
        istart[0] = 1'b1;
        ia[0] = 8'hF0;
        ib[0] = 8'h0F;
        ici[0] = 1'b0;
        @(posedge clk);
        #2;
        istart[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t4.busy", 32'(obusy[0]), 32'd0);
        chk("t4.done", 32'(odone[0]), 32'd0);
        chk("t4.s",    32'(os[0]),    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t4.no_done", 32'(odone[0]), 32'd0);
        end
        run_op(0, 8'hF0, 8'h0F, 1'b0, e, bc, hd);
        chk("t4.s_after", 32'(os[0]),  32'hFF);
        chk("t4.co_after", 32'(oco[0]), 32'd0);

        // WIDTH=4, CHUNK=1: every a, b, ci
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    run_op(1, 8'(av), 8'(bv), 1'(cv), e, bc, hd);
                    chk("t5.latency", 32'(e), 32'd4);
                    chk("t5.sum", 32'({oco[1], os[1][3:0]}), 32'(av + bv + cv));
                end
            end
        end

        // WIDTH=CHUNK=8: single RUN cycle
        run_op(2, 8'h7F, 8'h01, 1'b0, e, bc, hd);
        chk("t6.latency", 32'(e), 32'd1);
        chk("t6.s",   32'(os[2]),   32'h80);
        chk("t6.co",  32'(oco[2]),  32'd0);
        chk("t6.ovf", 32'(oovf[2]), 32'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
